// File: rtl/dmem_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dmem_responder_pkg
// Brief    : Shared bus widths and FSM state encoding for the data-memory
//            responder sitting behind the load/store unit.
// Revision : 1.0 - initial release
// ============================================================================
package dmem_responder_pkg;

  // Bus widths already used on the LSU side of the memory interface
  localparam int DMEM_XLEN   = 64;
  localparam int DMEM_MASK_W = DMEM_XLEN / 8;
  localparam int DMEM_ADDR_W = 32;

  // Latency counter width; holds LAT-1 for LAT in 1..15
  localparam int DMEM_CNT_W  = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

endpackage
`default_nettype wire

// File: rtl/dmem_array.sv
`default_nettype none
// ============================================================================
// Module   : dmem_array
// Brief    : XLEN x DEPTH word array with a byte-masked synchronous write
//            port and a registered read port (block-RAM friendly).
// Revision : 1.0 - initial release
// ============================================================================
module dmem_array #(
  parameter  int XLEN  = 64,
  parameter  int DEPTH = 4096,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic                clk_i,
  input  logic                we_i,
  input  logic                re_i,
  input  logic [IDX_W-1:0]    idx_i,
  input  logic [XLEN/8-1:0]   mask_i,
  input  logic [XLEN-1:0]     wdata_i,
  output logic [XLEN-1:0]     rdata_o
);

  logic [XLEN-1:0] mem [DEPTH];
  logic [XLEN-1:0] rdata_d;
  logic [XLEN-1:0] rdata_q;

  // Read register only reloads on a read so the data holds through backpressure
  always_comb begin
    rdata_d = rdata_q;
    if (re_i) begin
      rdata_d = mem[idx_i];
    end
  end

  // Registered read plus per-lane write; contents are deliberately not reset
  always_ff @(posedge clk_i) begin
    rdata_q <= rdata_d;
    if (we_i) begin
      for (int b = 0; b < XLEN / 8; b++) begin
        if (mask_i[b]) begin
          mem[idx_i][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : dmem_responder
// Brief    : Single-outstanding data-memory responder. Accepts one read or
//            byte-masked write, answers after LAT cycles over a valid/ready
//            response handshake, flags accesses outside the array window.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int              XLEN   = DMEM_XLEN,
  parameter int              ADDR_W = DMEM_ADDR_W,
  parameter int              DEPTH  = 4096,
  parameter logic [ADDR_W-1:0] BASE = 'h8000_0000,
  parameter int              LAT    = 2
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic                req_valid_i,
  output logic                req_ready_o,
  input  logic                req_wen_i,
  input  logic [ADDR_W-1:0]   addr_i,
  input  logic [XLEN/8-1:0]   mask_i,
  input  logic [XLEN-1:0]     wdata_i,
  output logic                resp_valid_o,
  input  logic                resp_ready_i,
  output logic [XLEN-1:0]     rdata_o,
  output logic                resp_err_o
);

  localparam int                   c_shift  = $clog2(XLEN / 8);
  localparam int                   c_idx_w  = $clog2(DEPTH);
  localparam logic [ADDR_W:0]      c_depth  = (ADDR_W + 1)'(DEPTH);
  localparam logic [DMEM_CNT_W-1:0] c_lat_m1 = DMEM_CNT_W'(LAT - 1);

  state_e                  state_q, state_d;
  logic [DMEM_CNT_W-1:0]   cnt_q, cnt_d;
  logic                    err_q, err_d;
  logic                    rd_q, rd_d;

  logic [ADDR_W-1:0]       w_off;
  logic [ADDR_W-1:0]       w_idx_full;
  logic                    w_in_range;
  logic                    w_idle;
  logic                    w_accept;
  logic                    w_arr_we;
  logic                    w_arr_re;
  logic [XLEN-1:0]         w_arr_rdata;

  // Range check: subtraction only trusted once addr_i >= BASE, so no wraparound
  always_comb begin
    w_off      = addr_i - BASE;
    w_idx_full = w_off >> c_shift;
    w_in_range = (addr_i >= BASE) && ({1'b0, w_idx_full} < c_depth);
  end

  // Anything that is not WAIT or RESP (including illegal codes) behaves as IDLE
  always_comb begin
    w_idle   = (state_q != ST_WAIT) && (state_q != ST_RESP);
    w_accept = w_idle && req_valid_i;
    w_arr_we = w_accept && req_wen_i && w_in_range;
    w_arr_re = w_accept && !req_wen_i && w_in_range;
  end

  dmem_array #(
    .XLEN  (XLEN),
    .DEPTH (DEPTH)
  ) u_array (
    .clk_i   (clk_i),
    .we_i    (w_arr_we),
    .re_i    (w_arr_re),
    .idx_i   (w_idx_full[c_idx_w-1:0]),
    .mask_i  (mask_i),
    .wdata_i (wdata_i),
    .rdata_o (w_arr_rdata)
  );

  // Next-state logic; every accept passes through WAIT so the response rises
  // exactly LAT edges after the acceptance edge
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    rd_d    = rd_q;
    case (state_q)
      ST_WAIT: begin
        if (cnt_q == '0) begin
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q - DMEM_CNT_W'(1);
        end
      end
      ST_RESP: begin
        if (resp_ready_i) begin
          state_d = ST_IDLE;
          err_d   = 1'b0;
          rd_d    = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        if (req_valid_i) begin
          state_d = ST_WAIT;
          cnt_d   = c_lat_m1;
          err_d   = !w_in_range;
          rd_d    = w_in_range && !req_wen_i;
        end
      end
    endcase
  end

  // Control state with asynchronous active-low reset; array is untouched
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      rd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      rd_q    <= rd_d;
    end
  end

  // Response outputs are zero outside RESP, and read data is zero for writes/errors
  always_comb begin
    req_ready_o  = w_idle;
    resp_valid_o = (state_q == ST_RESP);
    resp_err_o   = resp_valid_o && err_q;
    rdata_o      = (resp_valid_o && rd_q) ? w_arr_rdata : '0;
  end

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_responder
// Brief    : Self-checking bench for dmem_responder (LAT=2 and LAT=1 builds)
//            using a reference memory model and an expected-response queue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_responder;

  logic        clk;
  logic        rst_n;

  // LAT=2 instance
  logic        req_valid, req_ready, req_wen;
  logic [31:0] addr;
  logic [7:0]  mask;
  logic [63:0] wdata;
  logic        resp_valid, resp_ready, resp_err;
  logic [63:0] rdata;

  // LAT=1 instance
  logic        b_req_valid, b_req_ready, b_req_wen;
  logic [31:0] b_addr;
  logic [7:0]  b_mask;
  logic [63:0] b_wdata;
  logic        b_resp_valid, b_resp_ready, b_resp_err;
  logic [63:0] b_rdata;

  int tests_run    = 0;
  int tests_failed = 0;
  int cyc          = 0;

  logic [63:0] model [longint];
  logic [64:0] sb [$];

  dmem_responder #(.LAT(2)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_wen_i(req_wen),
    .addr_i(addr), .mask_i(mask), .wdata_i(wdata),
    .resp_valid_o(resp_valid), .resp_ready_i(resp_ready),
    .rdata_o(rdata), .resp_err_o(resp_err)
  );

  dmem_responder #(.LAT(1)) dut1 (
    .clk_i(clk), .rst_n_i(rst_n),
    .req_valid_i(b_req_valid), .req_ready_o(b_req_ready), .req_wen_i(b_req_wen),
    .addr_i(b_addr), .mask_i(b_mask), .wdata_i(b_wdata),
    .resp_valid_o(b_resp_valid), .resp_ready_i(b_resp_ready),
    .rdata_o(b_rdata), .resp_err_o(b_resp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: returns {err, rdata} and applies writes to the model
  function automatic logic [64:0] model_access(input logic w, input logic [31:0] a,
                                                input logic [7:0] m, input logic [63:0] d);
    logic [63:0] a64;
    logic [63:0] cur;
    longint      idx;
    a64 = {32'h0, a};
    if (a64 < 64'h8000_0000 || a64 >= 64'h8000_0000 + 64'd32768) return {1'b1, 64'h0};
    idx = longint'((a64 - 64'h8000_0000) >> 3);
    if (w) begin
      cur = model.exists(idx) ? model[idx] : 64'h0;
      for (int b = 0; b < 8; b++) if (m[b]) cur[8*b +: 8] = d[8*b +: 8];
      model[idx] = cur;
      return {1'b0, 64'h0};
    end
    return {1'b0, model[idx]};
  endfunction

  // One full transaction on the LAT=2 instance with resp_ready held high
  task automatic run_req(input logic w, input logic [31:0] a, input logic [7:0] m,
                         input logic [63:0] d, input string nm);
    logic [64:0] exp;
    int n;
    sb.push_back(model_access(w, a, m, d));
    resp_ready = 1'b1;
    @(negedge clk);
    req_valid = 1'b1; req_wen = w; addr = a; mask = m; wdata = d;
    tests_run++;
    if (req_ready !== 1'b1) begin
      tests_failed++; $display("FAIL %s ready: got %b expected 1", nm, req_ready);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    n = 0;
    while (resp_valid !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
    exp = sb.pop_front();
    tests_run++;
    if (n !== 2) begin
      tests_failed++; $display("FAIL %s latency: got %0d expected 2", nm, n);
    end
    tests_run++;
    if (rdata !== exp[63:0]) begin
      tests_failed++; $display("FAIL %s rdata: got %h expected %h", nm, rdata, exp[63:0]);
    end
    tests_run++;
    if (resp_err !== exp[64]) begin
      tests_failed++; $display("FAIL %s err: got %b expected %b", nm, resp_err, exp[64]);
    end
    @(posedge clk); #1;
    tests_run++;
    if ({resp_valid, resp_err, rdata, req_ready} !== {1'b0, 1'b0, 64'h0, 1'b1}) begin
      tests_failed++;
      $display("FAIL %s idle: got v=%b e=%b d=%h r=%b expected v=0 e=0 d=0 r=1",
               nm, resp_valid, resp_err, rdata, req_ready);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req_valid = 0; req_wen = 0; addr = 0; mask = 0; wdata = 0; resp_ready = 1;
    b_req_valid = 0; b_req_wen = 0; b_addr = 0; b_mask = 0; b_wdata = 0; b_resp_ready = 1;
    #1;
    tests_run++;
    if ({req_ready, resp_valid, resp_err, rdata} !== {1'b1, 1'b0, 1'b0, 64'h0}) begin
      tests_failed++;
      $display("FAIL reset_lat2: got r=%b v=%b e=%b d=%h expected r=1 v=0 e=0 d=0",
               req_ready, resp_valid, resp_err, rdata);
    end
    tests_run++;
    if ({b_req_ready, b_resp_valid, b_resp_err, b_rdata} !== {1'b1, 1'b0, 1'b0, 64'h0}) begin
      tests_failed++;
      $display("FAIL reset_lat1: got r=%b v=%b e=%b d=%h expected r=1 v=0 e=0 d=0",
               b_req_ready, b_resp_valid, b_resp_err, b_rdata);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_write_read();
    run_req(1'b1, 32'h8000_0010, 8'hFF, 64'h1122_3344_5566_7788, "wr_full");
    run_req(1'b0, 32'h8000_0010, 8'h00, 64'h0, "rd_full");
  endtask

  task automatic test_partial();
    run_req(1'b1, 32'h8000_0010, 8'h0F, 64'hAAAA_AAAA_DEAD_BEEF, "wr_part");
    run_req(1'b0, 32'h8000_0010, 8'h00, 64'h0, "rd_part");
    run_req(1'b1, 32'h8000_0010, 8'h00, 64'hFFFF_FFFF_FFFF_FFFF, "wr_mask0");
    run_req(1'b0, 32'h8000_0014, 8'h00, 64'h0, "rd_mask0_unaligned");
  endtask

  task automatic test_out_of_range();
    run_req(1'b1, 32'h8000_0000, 8'hFF, 64'h0123_4567_89AB_CDEF, "wr_word0");
    run_req(1'b0, 32'h7FFF_FFF8, 8'h00, 64'h0, "rd_below");
    run_req(1'b0, 32'h8000_8000, 8'h00, 64'h0, "rd_above");
    run_req(1'b1, 32'h8000_8000, 8'hFF, 64'hDEAD_DEAD_DEAD_DEAD, "wr_above");
    run_req(1'b1, 32'h8000_7FF8, 8'hFF, 64'h5A5A_0000_FFFF_A5A5, "wr_last");
    run_req(1'b0, 32'h8000_7FF8, 8'h00, 64'h0, "rd_last");
    run_req(1'b0, 32'h8000_0000, 8'h00, 64'h0, "rd_word0_after_oob");
    run_req(1'b0, 32'h8000_0010, 8'h00, 64'h0, "rd_word2_after_oob");
  endtask

  task automatic test_backpressure();
    logic [64:0] exp;
    int n;
    sb.push_back(model_access(1'b0, 32'h8000_0010, 8'h00, 64'h0));
    resp_ready = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_wen = 1'b0; addr = 32'h8000_0010; mask = 8'h00;
    @(posedge clk); #1;
    req_valid = 1'b0;
    n = 0;
    while (resp_valid !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
    exp = sb.pop_front();
    tests_run++;
    if (n !== 2) begin
      tests_failed++; $display("FAIL bp_latency: got %0d expected 2", n);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      tests_run++;
      if ({resp_valid, req_ready, resp_err, rdata} !== {1'b1, 1'b0, 1'b0, exp[63:0]}) begin
        tests_failed++;
        $display("FAIL bp_hold%0d: got v=%b r=%b e=%b d=%h expected v=1 r=0 e=0 d=%h",
                 i, resp_valid, req_ready, resp_err, rdata, exp[63:0]);
      end
      if (i < 4) begin
        // request presented while busy must be ignored
        req_valid = 1'b1; req_wen = 1'b1; mask = 8'hFF; wdata = 64'hBAD0_BAD0_BAD0_BAD0;
      end else begin
        req_valid = 1'b1; req_wen = 1'b0; mask = 8'h00; wdata = 64'h0;
        sb.push_back(model_access(1'b0, 32'h8000_0010, 8'h00, 64'h0));
        resp_ready = 1'b1;
      end
    end
    @(posedge clk); #1;
    tests_run++;
    if ({req_ready, resp_valid} !== 2'b10) begin
      tests_failed++;
      $display("FAIL bp_release: got r=%b v=%b expected r=1 v=0", req_ready, resp_valid);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    tests_run++;
    if (req_ready !== 1'b0) begin
      tests_failed++; $display("FAIL bp_reaccept: got ready=%b expected 0", req_ready);
    end
    n = 0;
    while (resp_valid !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
    exp = sb.pop_front();
    tests_run++;
    if (n !== 2 || rdata !== exp[63:0]) begin
      tests_failed++;
      $display("FAIL bp_second: got lat=%0d d=%h expected lat=2 d=%h", n, rdata, exp[63:0]);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_in_wait();
    void'(model_access(1'b1, 32'h8000_0100, 8'hFF, 64'hCAFE_F00D_1234_5678));
    resp_ready = 1'b1;
    @(negedge clk);
    req_valid = 1'b1; req_wen = 1'b1; addr = 32'h8000_0100; mask = 8'hFF;
    wdata = 64'hCAFE_F00D_1234_5678;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (resp_valid !== 1'b0) begin
      tests_failed++; $display("FAIL rst_wait_valid: got %b expected 0", resp_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    tests_run++;
    if ({req_ready, resp_valid} !== 2'b10) begin
      tests_failed++;
      $display("FAIL rst_wait_release: got r=%b v=%b expected r=1 v=0", req_ready, resp_valid);
    end
    run_req(1'b0, 32'h8000_0100, 8'h00, 64'h0, "rd_after_rst");
  endtask

  task automatic test_back_to_back();
    logic        lw [5];
    logic [31:0] la [5];
    logic [63:0] ld [5];
    int          acc [5];
    logic [64:0] exp;
    int          n;
    lw = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    la = '{32'h8000_0040, 32'h8000_0048, 32'h8000_0040, 32'h8000_0048, 32'h8000_8008};
    ld = '{64'h0F0E_0D0C_0B0A_0908, 64'h7766_5544_3322_1100, 64'h0, 64'h0, 64'h0};
    b_resp_ready = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      sb.push_back(model_access(lw[i], la[i], 8'hFF, ld[i]));
      b_req_valid = 1'b1; b_req_wen = lw[i]; b_addr = la[i]; b_mask = 8'hFF; b_wdata = ld[i];
      @(negedge clk);
      n = 0;
      while (b_req_ready !== 1'b1 && n < 10) begin @(negedge clk); n++; end
      @(posedge clk); #1;
      acc[i] = cyc;
      if (i == 4) b_req_valid = 1'b0;
      tests_run++;
      if ({b_resp_valid, b_req_ready} !== 2'b00) begin
        tests_failed++;
        $display("FAIL b2b_accept%0d: got v=%b r=%b expected v=0 r=0", i, b_resp_valid, b_req_ready);
      end
      @(posedge clk); #1;
      exp = sb.pop_front();
      tests_run++;
      if ({b_resp_valid, b_resp_err, b_rdata} !== {1'b1, exp}) begin
        tests_failed++;
        $display("FAIL b2b_resp%0d: got v=%b e=%b d=%h expected v=1 e=%b d=%h",
                 i, b_resp_valid, b_resp_err, b_rdata, exp[64], exp[63:0]);
      end
      if (i > 0) begin
        tests_run++;
        if (acc[i] - acc[i-1] !== 3) begin
          tests_failed++;
          $display("FAIL b2b_period%0d: got %0d expected 3", i, acc[i] - acc[i-1]);
        end
      end
      @(negedge clk);
    end
    @(posedge clk); #1;
    tests_run++;
    if ({b_resp_valid, b_req_ready} !== 2'b01) begin
      tests_failed++;
      $display("FAIL b2b_idle: got v=%b r=%b expected v=0 r=1", b_resp_valid, b_req_ready);
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_partial();
    test_out_of_range();
    test_backpressure();
    test_reset_in_wait();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
